compmul_accum: RTL and testbench

- Consumer end of the complex-multiplier array. Takes the five complex products r0..r4 (I/Q) and the array's busy flag.
- Reduces each product beat through a pipelined complex adder tree, then accumulates PASSES valid beats into one FIR output sample.
- Rounds, shifts and saturates the result to OUT_WIDTH, and emits it with a one-cycle valid pulse.
- Sits between the multiplier array and the output CDC FIFO of the FIR datapath.

---
 rtl/fir_pkg.sv | 69 ++++++
 rtl/compmul_accum_lane.sv | 70 +++++++
 rtl/compmul_accum.sv | 86 ++++++++
 tb/tb_compmul_accum.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - FIR datapath widths, saturation bounds and round/saturate helpers
// Helpers work on a 128-bit signed value so any output stage can reuse them.
package fir_pkg;

  localparam int S_WIDTH_DEF = 24;
  localparam int C_WIDTH_DEF = 27;
  localparam int P_WIDTH     = C_WIDTH_DEF + S_WIDTH_DEF + 1;
  localparam int TREE_WIDTH  = P_WIDTH + 3;
  localparam int RS_WIDTH    = 128;

  function automatic int p_width(input int s_width, input int c_width);
    return c_width + s_width + 1;
  endfunction

  function automatic int tree_width(input int p);
    return p + 3;
  endfunction

  function automatic int acc_width(input int t, input int passes);
    return t + $clog2(passes);
  endfunction

  function automatic logic signed [RS_WIDTH-1:0] sat_hi(input int out_width);
    return (128'sd1 <<< (out_width - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [RS_WIDTH-1:0] sat_lo(input int out_width);
    return -(128'sd1 <<< (out_width - 1));
  endfunction

  // Round half up, then arithmetic shift; shift == 0 passes the value through.
  function automatic logic signed [RS_WIDTH-1:0] round_shift(
    input logic signed [RS_WIDTH-1:0] x,
    input int shift
  );
    logic signed [RS_WIDTH-1:0] y;
    y = x;
    if (shift > 0) begin
      y = (x + (128'sd1 <<< (shift - 1))) >>> shift;
    end
    return y;
  endfunction

  function automatic logic signed [RS_WIDTH-1:0] rs_val(
    input logic signed [RS_WIDTH-1:0] x,
    input int shift,
    input int out_width
  );
    logic signed [RS_WIDTH-1:0] y;
    y = round_shift(x, shift);
    if (y > sat_hi(out_width)) begin
      y = sat_hi(out_width);
    end else if (y < sat_lo(out_width)) begin
      y = sat_lo(out_width);
    end
    return y;
  endfunction

  function automatic logic rs_ovf(
    input logic signed [RS_WIDTH-1:0] x,
    input int shift,
    input int out_width
  );
    logic signed [RS_WIDTH-1:0] y;
    y = round_shift(x, shift);
    return (y > sat_hi(out_width)) || (y < sat_lo(out_width));
  endfunction

endpackage

// File: rtl/compmul_accum_lane.sv
// rtl/compmul_accum_lane.sv - one component: 3-stage adder tree, beat accumulator, round/saturate
// Beat control (v3, first, last) comes from the top so I and Q stay in lockstep.
module compmul_accum_lane
  import fir_pkg::*;
#(
  parameter int P         = 52,
  parameter int T         = 55,
  parameter int A         = 58,
  parameter int OUT_WIDTH = 24,
  parameter int SHIFT     = 30
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [P-1:0]         r0,
  input  logic signed [P-1:0]         r1,
  input  logic signed [P-1:0]         r2,
  input  logic signed [P-1:0]         r3,
  input  logic signed [P-1:0]         r4,
  input  logic                        v3,
  input  logic                        first,
  input  logic                        last,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        sat
);

  logic signed [T-1:0] s01, s23, s4;
  logic signed [T-1:0] s0123, s4d;
  logic signed [T-1:0] sum;
  logic signed [A-1:0] acc;
  logic signed [A-1:0] sum_a;
  logic signed [A-1:0] total;

  // Tree loads every cycle; validity travels separately in the top.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s01   <= '0;
      s23   <= '0;
      s4    <= '0;
      s0123 <= '0;
      s4d   <= '0;
      sum   <= '0;
    end else begin
      s01   <= T'(r0) + T'(r1);
      s23   <= T'(r2) + T'(r3);
      s4    <= T'(r4);
      s0123 <= s01 + s23;
      s4d   <= s4;
      sum   <= s0123 + s4d;
    end
  end

  assign sum_a = A'(sum);
  assign total = first ? sum_a : acc + sum_a;
  assign sat   = last & rs_ovf(RS_WIDTH'(total), SHIFT, OUT_WIDTH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
      out <= '0;
    end else begin
      if (v3) begin
        acc <= total;
      end
      if (last) begin
        out <= OUT_WIDTH'(rs_val(RS_WIDTH'(total), SHIFT, OUT_WIDTH));
      end
    end
  end

endmodule

// File: rtl/compmul_accum.sv
// rtl/compmul_accum.sv - reduce five complex products per beat and accumulate PASSES beats per sample
// Owns the valid pipeline and beat counter shared by the I and Q lanes.
module compmul_accum
  import fir_pkg::*;
#(
  parameter int S_WIDTH   = 24,
  parameter int C_WIDTH   = 27,
  parameter int PASSES    = 8,
  parameter int OUT_WIDTH = 24,
  parameter int SHIFT     = 30
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             busy_in,
  input  logic signed [C_WIDTH+S_WIDTH:0]  r0I,
  input  logic signed [C_WIDTH+S_WIDTH:0]  r1I,
  input  logic signed [C_WIDTH+S_WIDTH:0]  r2I,
  input  logic signed [C_WIDTH+S_WIDTH:0]  r3I,
  input  logic signed [C_WIDTH+S_WIDTH:0]  r4I,
  input  logic signed [C_WIDTH+S_WIDTH:0]  r0Q,
  input  logic signed [C_WIDTH+S_WIDTH:0]  r1Q,
  input  logic signed [C_WIDTH+S_WIDTH:0]  r2Q,
  input  logic signed [C_WIDTH+S_WIDTH:0]  r3Q,
  input  logic signed [C_WIDTH+S_WIDTH:0]  r4Q,
  output logic signed [OUT_WIDTH-1:0]      outI,
  output logic signed [OUT_WIDTH-1:0]      outQ,
  output logic                             out_valid,
  output logic                             out_sat,
  output logic                             sat_sticky
);

  localparam int P  = p_width(S_WIDTH, C_WIDTH);
  localparam int T  = tree_width(P);
  localparam int A  = acc_width(T, PASSES);
  localparam int CW = (PASSES > 1) ? $clog2(PASSES) : 1;

  logic          v1, v2, v3;
  logic [CW-1:0] beat_cnt;
  logic          first, last;
  logic          sat_i, sat_q;

  assign first = (beat_cnt == '0);
  assign last  = v3 && (beat_cnt == CW'(PASSES - 1));

  // Idle cycles freeze beat_cnt so a partial frame resumes after any gap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      beat_cnt   <= '0;
      out_valid  <= 1'b0;
      out_sat    <= 1'b0;
      sat_sticky <= 1'b0;
    end else begin
      v1 <= busy_in;
      v2 <= v1;
      v3 <= v2;
      if (v3) begin
        beat_cnt <= last ? '0 : beat_cnt + 1'b1;
      end
      out_valid  <= last;
      out_sat    <= sat_i | sat_q;
      sat_sticky <= sat_sticky | sat_i | sat_q;
    end
  end

  compmul_accum_lane #(
    .P(P), .T(T), .A(A), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)
  ) u_lane_i (
    .clk(clk), .reset(reset),
    .r0(r0I), .r1(r1I), .r2(r2I), .r3(r3I), .r4(r4I),
    .v3(v3), .first(first), .last(last),
    .out(outI), .sat(sat_i)
  );

  compmul_accum_lane #(
    .P(P), .T(T), .A(A), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)
  ) u_lane_q (
    .clk(clk), .reset(reset),
    .r0(r0Q), .r1(r1Q), .r2(r2Q), .r3(r3Q), .r4(r4Q),
    .v3(v3), .first(first), .last(last),
    .out(outQ), .sat(sat_q)
  );

endmodule

// File: tb/tb_compmul_accum.sv
// tb/tb_compmul_accum.sv - directed bench for compmul_accum, SHIFT=0 and SHIFT=2 instances on shared stimulus
module tb_compmul_accum;

  localparam int PW = 52;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy = 1'b0;
  logic signed [PW-1:0] ri [5];
  logic signed [PW-1:0] rq [5];

  logic signed [23:0] oi0, oq0, oi2, oq2;
  logic ov0, os0, ss0, ov2, os2, ss2;

  int cyc = 0;
  int total = 0;
  int passed = 0;
  int last_cyc;

  typedef struct {
    int                 c;
    logic signed [23:0] i;
    logic signed [23:0] q;
    logic               s;
  } ev_t;
  ev_t ev0 [$];
  ev_t ev2 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ov0) ev0.push_back('{cyc, oi0, oq0, os0});
    if (ov2) ev2.push_back('{cyc, oi2, oq2, os2});
  end

  compmul_accum #(.PASSES(8), .OUT_WIDTH(24), .SHIFT(0)) dut0 (
    .clk(clk), .reset(rst_n), .busy_in(busy),
    .r0I(ri[0]), .r1I(ri[1]), .r2I(ri[2]), .r3I(ri[3]), .r4I(ri[4]),
    .r0Q(rq[0]), .r1Q(rq[1]), .r2Q(rq[2]), .r3Q(rq[3]), .r4Q(rq[4]),
    .outI(oi0), .outQ(oq0), .out_valid(ov0), .out_sat(os0), .sat_sticky(ss0)
  );

  compmul_accum #(.PASSES(8), .OUT_WIDTH(24), .SHIFT(2)) dut2 (
    .clk(clk), .reset(rst_n), .busy_in(busy),
    .r0I(ri[0]), .r1I(ri[1]), .r2I(ri[2]), .r3I(ri[3]), .r4I(ri[4]),
    .r0Q(rq[0]), .r1Q(rq[1]), .r2Q(rq[2]), .r3Q(rq[3]), .r4Q(rq[4]),
    .outI(oi2), .outQ(oq2), .out_valid(ov2), .out_sat(os2), .sat_sticky(ss2)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input longint iv, input longint qv);
    busy = b;
    for (int k = 0; k < 5; k++) begin
      ri[k] = PW'(iv);
      rq[k] = PW'(qv);
    end
  endtask

  task automatic beat(input longint iv, input longint qv);
    drive(1'b1, iv, qv);
    tick();
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 0, 0);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_oi0"}, oi0, 0);
    check({tag, "_oq0"}, oq0, 0);
    check({tag, "_ov0"}, ov0, 0);
    check({tag, "_os0"}, os0, 0);
    check({tag, "_ss0"}, ss0, 0);
    check({tag, "_oi2"}, oi2, 0);
    check({tag, "_ov2"}, ov2, 0);
    check({tag, "_ss2"}, ss2, 0);
  endtask

  // Waits a fixed window after the last beat, then checks exactly one pulse per instance.
  task automatic check_frame(input string tag,
                             input longint i0, input longint q0, input logic s0,
                             input longint i2, input longint q2, input logic s2);
    idle(6);
    check({tag, "_cnt0"}, ev0.size(), 1);
    check({tag, "_cnt2"}, ev2.size(), 1);
    if (ev0.size() > 0) begin
      check({tag, "_lat0"}, ev0[0].c - last_cyc, 3);
      check({tag, "_i0"}, ev0[0].i, i0);
      check({tag, "_q0"}, ev0[0].q, q0);
      check({tag, "_s0"}, ev0[0].s, s0);
    end
    if (ev2.size() > 0) begin
      check({tag, "_lat2"}, ev2[0].c - last_cyc, 3);
      check({tag, "_i2"}, ev2[0].i, i2);
      check({tag, "_q2"}, ev2[0].q, q2);
      check({tag, "_s2"}, ev2[0].s, s2);
    end
    check({tag, "_hold_i0"}, oi0, i0);
    check({tag, "_idle_ov0"}, ov0, 0);
    check({tag, "_idle_os0"}, os0, 0);
    ev0.delete();
    ev2.delete();
  endtask

  initial begin
    drive(1'b0, 0, 0);
    rst_n = 1'b0;
    idle(3);
    check_reset_state("reset");
    rst_n = 1'b1;
    idle(2);
    ev0.delete();
    ev2.delete();

    // Single frame: 8 beats of I=1, Q=-2 on all five products.
    for (int b = 0; b < 8; b++) beat(1, -2);
    check_frame("single", 40, -80, 1'b0, 10, -20, 1'b0);

    // Same frame with a 3-cycle gap after beat 3.
    for (int b = 0; b < 4; b++) beat(1, -2);
    idle(3);
    check("gap_no_pulse", ev0.size(), 0);
    for (int b = 0; b < 4; b++) beat(1, -2);
    check_frame("gapped", 40, -80, 1'b0, 10, -20, 1'b0);

    // Rounding: frame total I=6, Q=-6 carried on r0 only.
    drive(1'b1, 0, 0);
    ri[0] = 52'sd6;
    rq[0] = -52'sd6;
    tick();
    for (int b = 0; b < 7; b++) beat(0, 0);
    check_frame("round", 6, -6, 1'b0, 2, -1, 1'b0);

    // Saturation: r0I = 2^22 for 8 beats gives 2^25.
    for (int b = 0; b < 8; b++) begin
      drive(1'b1, 0, 0);
      ri[0] = 52'sd4194304;
      tick();
      last_cyc = cyc;
    end
    check_frame("sat", 8388607, 0, 1'b1, 8388607, 0, 1'b1);
    check("sat_sticky0", ss0, 1);
    check("sat_sticky2", ss2, 1);

    // Clean frame after saturation: out_sat clear, sticky stays.
    for (int b = 0; b < 8; b++) beat(1, -2);
    check_frame("clean", 40, -80, 1'b0, 10, -20, 1'b0);
    check("sticky_hold0", ss0, 1);
    check("sticky_hold2", ss2, 1);

    // Back-to-back frames: I = beat index on every product.
    for (int b = 0; b < 16; b++) beat(b, 0);
    idle(6);
    check("b2b_cnt0", ev0.size(), 2);
    check("b2b_cnt2", ev2.size(), 2);
    if (ev0.size() == 2) begin
      check("b2b_gap0", ev0[1].c - ev0[0].c, 8);
      check("b2b_lat0", ev0[1].c - last_cyc, 3);
      check("b2b_i0_f0", ev0[0].i, 140);
      check("b2b_i0_f1", ev0[1].i, 460);
      check("b2b_q0_f1", ev0[1].q, 0);
    end
    if (ev2.size() == 2) begin
      check("b2b_i2_f0", ev2[0].i, 35);
      check("b2b_i2_f1", ev2[1].i, 115);
    end
    ev0.delete();
    ev2.delete();

    // Reset mid-frame: 5 beats, 1-cycle reset, then a full frame.
    for (int b = 0; b < 5; b++) beat(1, -2);
    drive(1'b0, 0, 0);
    rst_n = 1'b0;
    tick();
    check_reset_state("midrst");
    rst_n = 1'b1;
    idle(5);
    check("midrst_no_pulse", ev0.size(), 0);
    check("midrst_hold_i0", oi0, 0);
    for (int b = 0; b < 8; b++) beat(1, -2);
    check_frame("after_rst", 40, -80, 1'b0, 10, -20, 1'b0);
    check("after_rst_sticky0", ss0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
